memory_stage: RTL and testbench

Memory stage of the hybrid ARM/MIPS pipeline; consumes the Execute stage's result bundle (ALU result, store data, destination register, write-back controls) and completes the access. It holds an EX/MEM latch, performs a req/ack handshake to data memory or to the IO bus, and issues single-cycle writes to pixel memory. It stalls upstream while an access is outstanding, and drives a registered MEM/WB bundle to Writeback.

---
 rtl/mem_stage_pkg.sv | 37 +++
 rtl/mem_access_fsm.sv | 88 ++++++++
 rtl/memory_stage.sv | 127 ++++++++++++
 tb/tb_memory_stage.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: FSM states, write-back select codes and
// the EX/MEM and MEM/WB control bundles.
package mem_stage_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_pwrite;
        logic       io_flag;
        logic [1:0] mem_to_reg;
        logic [3:0] rd;
    } ex_ctrl_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic [3:0] rd;
    } wb_ctrl_t;

    localparam wb_ctrl_t WB_BUBBLE = '{valid: 1'b0, reg_write: 1'b0,
                                       mem_to_reg: WB_ALU, rd: 4'd0};

    // Pixel writes take priority, so a bundle with MemPWrite never handshakes.
    function automatic logic is_mem_op(input ex_ctrl_t c);
        return (c.mem_write || (c.mem_to_reg == WB_LOAD)) && !c.mem_pwrite;
    endfunction

endpackage

// File: rtl/mem_access_fsm.sv
// Request/ack sequencer for the memory stage: owns state, stall, req/we and,
// when MEM_STAGE_TIMEOUT_EN is defined, the watchdog counter and mem_err.
module mem_access_fsm
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 8
)
(
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_start_io,
    input  logic i_start_we,
    input  logic i_dmem_ack,
    input  logic i_io_ack,
    output logic o_stall,
    output logic o_abort,
    output logic o_dmem_req,
    output logic o_dmem_we,
    output logic o_io_req,
    output logic o_io_we,
    output logic o_mem_err
);

    state_t r_state;
    logic   r_dmem_req;
    logic   r_dmem_we;
    logic   r_io_req;
    logic   r_io_we;
    logic   w_ack;
    logic   w_abort;
    logic   w_accept;

    // Only the ack of the bus actually being driven counts; stale acks are dropped.
    assign w_ack    = (r_dmem_req & i_dmem_ack) | (r_io_req & i_io_ack);
    assign w_accept = (r_state == IDLE) | w_ack | w_abort;

    assign o_stall    = ~w_accept;
    assign o_abort    = w_abort;
    assign o_dmem_req = r_dmem_req;
    assign o_dmem_we  = r_dmem_we;
    assign o_io_req   = r_io_req;
    assign o_io_we    = r_io_we;

`ifdef MEM_STAGE_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_cnt;
    logic                 r_mem_err;

    assign w_abort   = (r_state == ACCESS) & ~w_ack & (r_cnt == '1);
    assign o_mem_err = r_mem_err;
`else
    assign w_abort   = 1'b0;
    assign o_mem_err = 1'b0 && (TIMEOUT_W > 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_io_req   <= 1'b0;
            r_io_we    <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
            r_cnt      <= '0;
            r_mem_err  <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_state    <= i_start ? ACCESS : IDLE;
                r_dmem_req <= i_start & ~i_start_io;
                r_dmem_we  <= i_start & ~i_start_io & i_start_we;
                r_io_req   <= i_start & i_start_io;
                r_io_we    <= i_start & i_start_io & i_start_we;
            end
`ifdef MEM_STAGE_TIMEOUT_EN
            if (w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_abort) begin
                r_mem_err <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: rtl/memory_stage.sv
// Memory stage: EX/MEM latch, dmem/IO handshake via mem_access_fsm, pixel
// write strobe and MEM/WB latch. Optional watchdog: MEM_STAGE_TIMEOUT_EN.
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned N         = 32,
    parameter int unsigned TIMEOUT_W = 8
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         RegWrite,
    input  logic         MemWrite,
    input  logic         MemPWrite,
    input  logic         IOFlag,
    input  logic [1:0]   MemToReg,
    input  logic [N-1:0] ALUResult,
    input  logic [N-1:0] WriteData,
    input  logic [3:0]   Rd,
    input  logic         ex_valid,
    output logic         stall,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic         io_req,
    output logic         io_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic [N-1:0] dmem_rdata,
    input  logic [N-1:0] io_rdata,
    input  logic         dmem_ack,
    input  logic         io_ack,
    output logic         pix_we,
    output logic         wb_valid,
    output logic         wb_reg_write,
    output logic [1:0]   wb_mem_to_reg,
    output logic [N-1:0] wb_alu_result,
    output logic [N-1:0] wb_read_data,
    output logic [3:0]   wb_rd,
    output logic         mem_err
);

    ex_ctrl_t     w_ex_ctrl;
    ex_ctrl_t     r_m_ctrl;
    logic         r_m_valid;
    logic [N-1:0] r_m_alu;
    logic [N-1:0] r_m_wdata;
    wb_ctrl_t     r_w_ctrl;
    logic [N-1:0] r_w_alu;
    logic [N-1:0] r_w_rdata;
    logic         w_stall;
    logic         w_abort;
    logic         w_start;
    logic         w_m_load;
    logic [N-1:0] w_rdata;

    assign w_ex_ctrl = '{reg_write: RegWrite, mem_write: MemWrite,
                         mem_pwrite: MemPWrite, io_flag: IOFlag,
                         mem_to_reg: MemToReg, rd: Rd};

    assign w_start  = ex_valid & is_mem_op(w_ex_ctrl);
    assign w_m_load = r_m_valid & ~r_m_ctrl.mem_write & ~r_m_ctrl.mem_pwrite
                    & (r_m_ctrl.mem_to_reg == WB_LOAD);
    assign w_rdata  = r_m_ctrl.io_flag ? io_rdata : dmem_rdata;

    mem_access_fsm #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_fsm (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_start_io (IOFlag),
        .i_start_we (MemWrite),
        .i_dmem_ack (dmem_ack),
        .i_io_ack   (io_ack),
        .o_stall    (w_stall),
        .o_abort    (w_abort),
        .o_dmem_req (dmem_req),
        .o_dmem_we  (dmem_we),
        .o_io_req   (io_req),
        .o_io_we    (io_we),
        .o_mem_err  (mem_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_ctrl  <= '0;
            r_m_alu   <= '0;
            r_m_wdata <= '0;
        end else if (!w_stall) begin
            r_m_valid <= ex_valid;
            r_m_ctrl  <= w_ex_ctrl;
            r_m_alu   <= ALUResult;
            r_m_wdata <= WriteData;
        end
    end

    // An aborted access retires as a bubble, same as a stalled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w_ctrl  <= WB_BUBBLE;
            r_w_alu   <= '0;
            r_w_rdata <= '0;
        end else if (w_stall || w_abort || !r_m_valid) begin
            r_w_ctrl  <= WB_BUBBLE;
            r_w_alu   <= '0;
            r_w_rdata <= '0;
        end else begin
            r_w_ctrl  <= '{valid: 1'b1, reg_write: r_m_ctrl.reg_write,
                           mem_to_reg: r_m_ctrl.mem_to_reg, rd: r_m_ctrl.rd};
            r_w_alu   <= r_m_alu;
            r_w_rdata <= w_m_load ? w_rdata : '0;
        end
    end

    assign stall         = w_stall;
    assign mem_addr      = r_m_alu;
    assign mem_wdata     = r_m_wdata;
    assign pix_we        = r_m_valid & r_m_ctrl.mem_pwrite;
    assign wb_valid      = r_w_ctrl.valid;
    assign wb_reg_write  = r_w_ctrl.reg_write;
    assign wb_mem_to_reg = r_w_ctrl.mem_to_reg;
    assign wb_rd         = r_w_ctrl.rd;
    assign wb_alu_result = r_w_alu;
    assign wb_read_data  = r_w_rdata;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU, load/store handshakes, pixel writes,
// reset mid-access and (with MEM_STAGE_TIMEOUT_EN) the watchdog abort.
module tb_memory_stage;

    logic        clk;
    logic        rst;
    logic        RegWrite, MemWrite, MemPWrite, IOFlag;
    logic [1:0]  MemToReg;
    logic [31:0] ALUResult, WriteData;
    logic [3:0]  Rd;
    logic        ex_valid;
    logic        stall;
    logic        dmem_req, dmem_we, io_req, io_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] dmem_rdata, io_rdata;
    logic        dmem_ack, io_ack;
    logic        pix_we;
    logic        wb_valid, wb_reg_write;
    logic [1:0]  wb_mem_to_reg;
    logic [31:0] wb_alu_result, wb_read_data;
    logic [3:0]  wb_rd;
    logic        mem_err;

    int n_cmp = 0;
    int n_bad = 0;

    memory_stage #(
        .N         (32),
        .TIMEOUT_W (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .RegWrite      (RegWrite),
        .MemWrite      (MemWrite),
        .MemPWrite     (MemPWrite),
        .IOFlag        (IOFlag),
        .MemToReg      (MemToReg),
        .ALUResult     (ALUResult),
        .WriteData     (WriteData),
        .Rd            (Rd),
        .ex_valid      (ex_valid),
        .stall         (stall),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .io_req        (io_req),
        .io_we         (io_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .dmem_rdata    (dmem_rdata),
        .io_rdata      (io_rdata),
        .dmem_ack      (dmem_ack),
        .io_ack        (io_ack),
        .pix_we        (pix_we),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_alu_result (wb_alu_result),
        .wb_read_data  (wb_read_data),
        .wb_rd         (wb_rd),
        .mem_err       (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mw, input logic pw,
                         input logic io, input logic [1:0] m2r, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [3:0] rd);
        ex_valid  = v;
        RegWrite  = rw;
        MemWrite  = mw;
        MemPWrite = pw;
        IOFlag    = io;
        MemToReg  = m2r;
        ALUResult = alu;
        WriteData = wd;
        Rd        = rd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        int stalls;
        rst        = 1'b1;
        idle();
        dmem_rdata = 32'h0;
        io_rdata   = 32'h0;
        dmem_ack   = 1'b0;
        io_ack     = 1'b0;
        cyc();

        chk("rst_stall",     stall,         0);
        chk("rst_dmem_req",  dmem_req,      0);
        chk("rst_dmem_we",   dmem_we,       0);
        chk("rst_io_req",    io_req,        0);
        chk("rst_io_we",     io_we,         0);
        chk("rst_pix_we",    pix_we,        0);
        chk("rst_mem_addr",  mem_addr,      0);
        chk("rst_mem_wdata", mem_wdata,     0);
        chk("rst_wb_valid",  wb_valid,      0);
        chk("rst_wb_rw",     wb_reg_write,  0);
        chk("rst_wb_m2r",    wb_mem_to_reg, 0);
        chk("rst_wb_alu",    wb_alu_result, 0);
        chk("rst_wb_rdata",  wb_read_data,  0);
        chk("rst_wb_rd",     wb_rd,         0);
        chk("rst_mem_err",   mem_err,       0);
        rst = 1'b0;
        cyc();

        // ALU op: two edges to write-back, no stall
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0000_00AA, 32'h0, 4'd3);
        cyc();
        idle();
        chk("alu_stall_m",   stall,    0);
        chk("alu_wbv_early", wb_valid, 0);
        cyc();
        chk("alu_wb_valid",  wb_valid,      1);
        chk("alu_wb_rw",     wb_reg_write,  1);
        chk("alu_wb_result", wb_alu_result, 32'hAA);
        chk("alu_wb_rd",     wb_rd,         3);
        chk("alu_wb_rdata",  wb_read_data,  0);
        chk("alu_stall_w",   stall,         0);

        // Load from dmem, ack withheld for three cycles
        dmem_rdata = 32'hDEAD_BEEF;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'h100, 32'h9999, 4'd5);
        cyc();
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("ld_stall",    stall,    1);
            chk("ld_dmem_req", dmem_req, 1);
            chk("ld_dmem_we",  dmem_we,  0);
            chk("ld_addr",     mem_addr, 32'h100);
            chk("ld_bubble",   wb_valid, 0);
            cyc();
        end
        dmem_ack = 1'b1;
        #1;
        chk("ld_ack_stall", stall, 0);
        cyc();
        dmem_ack = 1'b0;
        chk("ld_wb_valid", wb_valid,      1);
        chk("ld_wb_rdata", wb_read_data,  32'hDEAD_BEEF);
        chk("ld_wb_rd",    wb_rd,         5);
        chk("ld_wb_m2r",   wb_mem_to_reg, 1);
        chk("ld_wb_rw",    wb_reg_write,  1);
        chk("ld_req_drop", dmem_req,      0);
        chk("ld_stall_end", stall,        0);

        // IO store; a dmem ack during an IO access must not release the stall
        io_rdata = 32'h7777_7777;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 32'h40, 32'h1234, 4'd7);
        cyc();
        idle();
        chk("io_req",      io_req,    1);
        chk("io_we",       io_we,     1);
        chk("io_wdata",    mem_wdata, 32'h1234);
        chk("io_addr",     mem_addr,  32'h40);
        chk("io_dmem_req", dmem_req,  0);
        chk("io_stall",    stall,     1);
        dmem_ack = 1'b1;
        #1;
        chk("io_wrong_ack", stall, 1);
        io_ack = 1'b1;
        #1;
        chk("io_ack_stall", stall, 0);
        cyc();
        io_ack   = 1'b0;
        dmem_ack = 1'b0;
        chk("io_wb_valid", wb_valid,     1);
        chk("io_wb_rw",    wb_reg_write, 0);
        chk("io_wb_rdata", wb_read_data, 0);
        chk("io_req_drop", io_req,       0);

        // Pixel write with MemWrite also set: strobe only, no handshake
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 32'h8000, 32'h00FF, 4'd0);
        cyc();
        idle();
        chk("pix_we",       pix_we,    1);
        chk("pix_addr",     mem_addr,  32'h8000);
        chk("pix_wdata",    mem_wdata, 32'h00FF);
        chk("pix_dmem_req", dmem_req,  0);
        chk("pix_io_req",   io_req,    0);
        chk("pix_stall",    stall,     0);
        cyc();
        chk("pix_we_drop",  pix_we,    0);
        chk("pix_wb_valid", wb_valid,  1);
        chk("pix_req_late", dmem_req,  0);

        // Stale acks while idle
        dmem_ack = 1'b1;
        io_ack   = 1'b1;
        #1;
        chk("stale_stall", stall, 0);
        cyc();
        chk("stale_dreq", dmem_req, 0);
        chk("stale_ireq", io_req,   0);
        dmem_ack = 1'b0;
        io_ack   = 1'b0;

        // Back-to-back ALU ops
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h11, 32'h0, 4'd1);
        cyc();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h22, 32'h0, 4'd2);
        chk("b2b_stall", stall, 0);
        cyc();
        idle();
        chk("b2b_res_a", wb_alu_result, 32'h11);
        chk("b2b_rd_a",  wb_rd,         1);
        cyc();
        chk("b2b_res_b", wb_alu_result, 32'h22);
        chk("b2b_rd_b",  wb_rd,         2);
        chk("b2b_valid", wb_valid,      1);

        // Ack in the first ACCESS cycle: zero stall
        dmem_rdata = 32'hCAFE_0001;
        dmem_ack   = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'h200, 32'h0, 4'd9);
        cyc();
        idle();
        chk("zs_req",   dmem_req, 1);
        chk("zs_stall", stall,    0);
        cyc();
        dmem_ack = 1'b0;
        chk("zs_rdata", wb_read_data, 32'hCAFE_0001);
        chk("zs_valid", wb_valid,     1);
        chk("zs_rd",    wb_rd,        9);
        chk("zs_req_drop", dmem_req,  0);

        // Reset during ACCESS, then a normal load
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'h300, 32'h0, 4'd4);
        cyc();
        idle();
        chk("rm_req",   dmem_req, 1);
        chk("rm_stall", stall,    1);
        rst = 1'b1;
        #1;
        chk("rm_req_drop", dmem_req,      0);
        chk("rm_stall0",   stall,         0);
        chk("rm_wb_valid", wb_valid,      0);
        chk("rm_wb_alu",   wb_alu_result, 0);
        chk("rm_wb_rd",    wb_rd,         0);
        chk("rm_addr",     mem_addr,      0);
        cyc();
        rst = 1'b0;
        dmem_rdata = 32'h5555_AAAA;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'h104, 32'h0, 4'd6);
        cyc();
        idle();
        chk("rl_req",   dmem_req, 1);
        chk("rl_addr",  mem_addr, 32'h104);
        chk("rl_stall", stall,    1);
        dmem_ack = 1'b1;
        #1;
        chk("rl_ack_stall", stall, 0);
        cyc();
        dmem_ack = 1'b0;
        chk("rl_rdata", wb_read_data, 32'h5555_AAAA);
        chk("rl_valid", wb_valid,     1);
        chk("rl_rd",    wb_rd,        6);

`ifdef MEM_STAGE_TIMEOUT_EN
        // Never-acked load: 15 stall cycles, then abort
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 32'h500, 32'h0, 4'd8);
        cyc();
        idle();
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            if (!stall) break;
            stalls++;
            cyc();
        end
        chk("to_stall_cycles", stalls, 15);
        chk("to_stall_abort",  stall,  0);
        cyc();
        chk("to_mem_err",  mem_err,  1);
        chk("to_wb_valid", wb_valid, 0);
        chk("to_req_drop", dmem_req, 0);
        cyc();
        cyc();
        chk("to_sticky",   mem_err,  1);
`else
        stalls = 0;
        chk("no_to_mem_err", mem_err, stalls);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
